// File: rtl/out_requant_stream_if.sv
// Row-in / beat-out stream bundle for out_requant_stream: row push handshake, beat pop handshake, sticky saturation status.
interface out_requant_stream_if #(
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_LANES  = 4
);
    localparam int PSUM_WIDTH = 2 * DATA_WIDTH;

    logic                  in_valid;
    logic                  in_ready;
    logic [PSUM_WIDTH-1:0] in_data [0:SYS_COL-1];
    logic [4:0]            shift;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data [0:OUT_LANES-1];
    logic                  out_last;
    logic                  sat_flag;
    logic                  sat_clr;

    modport master (
        output in_valid, in_data, shift, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_last, sat_flag
    );

    modport slave (
        input  in_valid, in_data, shift, out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_last, sat_flag
    );
endinterface

// File: rtl/out_requant_stream.sv
// Requantizes accepted psum rows (round, shift, saturate) into a ROW_DEPTH row FIFO, then streams each row out as BEATS beats.
// One cycle from accept to first beat; in_ready/out_valid come only from registered occupancy, so no input-to-output comb path.
module out_requant_stream #(
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_LANES  = 4,
    parameter int ROW_DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    out_requant_stream_if.slave bus
);
    localparam int PSUM_WIDTH = 2 * DATA_WIDTH;
    localparam int BEATS      = SYS_COL / OUT_LANES;
    localparam int PW         = $clog2(ROW_DEPTH);
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW         = (SYS_COL > 1) ? $clog2(SYS_COL) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(ROW_DEPTH);
    localparam logic [5:0]    SHIFT_MAX = 6'(PSUM_WIDTH - 1);

    localparam logic signed [PSUM_WIDTH:0] SAT_MAX =
        {{(PSUM_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PSUM_WIDTH:0] SAT_MIN =
        {{(PSUM_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Returns {saturated, value}; one guard bit keeps the rounding add from overflowing.
    function automatic logic [DATA_WIDTH:0] requant(input logic [PSUM_WIDTH-1:0] v,
                                                    input logic [4:0]            s);
        logic signed [PSUM_WIDTH:0] ext;
        logic signed [PSUM_WIDTH:0] rnd;
        logic signed [PSUM_WIDTH:0] res;
        logic                       sat_hi;
        logic                       sat_lo;
        logic [DATA_WIDTH-1:0]      q;
        ext    = signed'({v[PSUM_WIDTH-1], v});
        rnd    = (s == 5'd0) ? '0 : ((PSUM_WIDTH+1)'(1) << (s - 5'd1));
        res    = (ext + rnd) >>> s;
        sat_hi = res > SAT_MAX;
        sat_lo = res < SAT_MIN;
        q      = sat_hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                 sat_lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : res[DATA_WIDTH-1:0];
        return {sat_hi | sat_lo, q};
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [0:ROW_DEPTH-1][0:SYS_COL-1];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW:0]           r_count;
    logic [BW-1:0]         r_beat;
    logic                  r_sat;

    logic [4:0]            w_shift;
    logic [DATA_WIDTH-1:0] w_q [0:SYS_COL-1];
    logic                  w_any_sat;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_push;
    logic                  w_xfer;
    logic                  w_pop;

    always_comb begin
        logic [DATA_WIDTH:0] lane;
        w_shift   = ({1'b0, bus.shift} > SHIFT_MAX) ? SHIFT_MAX[4:0] : bus.shift;
        w_any_sat = 1'b0;
        for (int k = 0; k < SYS_COL; k++) begin
            lane      = requant(bus.in_data[k], w_shift);
            w_q[k]    = lane[DATA_WIDTH-1:0];
            w_any_sat = w_any_sat | lane[DATA_WIDTH];
        end
    end

    assign w_in_ready  = (r_count < FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_xfer      = w_out_valid && bus.out_ready;
    assign w_pop       = w_xfer && (r_beat == LAST_BEAT);

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_valid && (r_beat == LAST_BEAT);
    assign bus.sat_flag  = r_sat;

    always_comb begin
        for (int i = 0; i < OUT_LANES; i++) begin
            bus.out_data[i] = r_mem[r_rptr][LW'(int'(r_beat) * OUT_LANES + i)];
        end
    end

    // Row storage carries no reset: contents are only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int k = 0; k < SYS_COL; k++) begin
                r_mem[r_wptr][k] <= w_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_xfer) begin
                r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BW'(1);
            end
            // A new saturation outranks a simultaneous clear.
            if (w_push && w_any_sat) begin
                r_sat <= 1'b1;
            end else if (bus.sat_clr) begin
                r_sat <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_out_requant_stream.sv
// Directed bench for out_requant_stream: requant vector table plus hand sequences for streaming, backpressure, saturation and reset.
module tb_out_requant_stream;
    localparam int SYS_COL    = 16;
    localparam int DATA_WIDTH = 16;
    localparam int OUT_LANES  = 4;
    localparam int ROW_DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    out_requant_stream_if #(.SYS_COL(SYS_COL), .DATA_WIDTH(DATA_WIDTH), .OUT_LANES(OUT_LANES)) bus();

    out_requant_stream #(
        .SYS_COL(SYS_COL), .DATA_WIDTH(DATA_WIDTH), .OUT_LANES(OUT_LANES), .ROW_DEPTH(ROW_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] val;
        logic [4:0]  sh;
        logic [15:0] exp;
        logic        sat;
        string       name;
    } vec_t;

    vec_t vt [14];

    int          mrows;
    int          mbeat;
    int          next_id;
    int          id_limit;
    logic [15:0] expq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_word();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < OUT_LANES; i++) w = (w << DATA_WIDTH) | 64'(bus.out_data[i]);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_row_const(input logic [31:0] val, input logic [4:0] sh);
        for (int k = 0; k < SYS_COL; k++) bus.in_data[k] = val;
        bus.shift = sh;
    endtask

    // Lane value (id*16+k)*16+7 with shift 4 rounds back to id*16+k.
    task automatic load_row(input int id);
        for (int k = 0; k < SYS_COL; k++) bus.in_data[k] = 32'((id * 16 + k) * 16 + 7);
        bus.shift = 5'd4;
    endtask

    task automatic mcycle(input bit vld, input bit rdy);
        bit          push;
        bit          xfer;
        logic [63:0] e;
        bus.in_valid  = vld && (next_id < id_limit);
        if (bus.in_valid) load_row(next_id);
        bus.out_ready = rdy;
        chk("in_ready", 64'(bus.in_ready), 64'(mrows < ROW_DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'(mrows != 0));
        push = bus.in_valid && (mrows < ROW_DEPTH);
        xfer = rdy && (mrows != 0);
        if (xfer) begin
            e = '0;
            for (int i = 0; i < OUT_LANES; i++) e = (e << DATA_WIDTH) | 64'(expq[i]);
            chk("beat_data", beat_word(), e);
            chk("beat_last", 64'(bus.out_last), 64'(mbeat == 3));
        end
        tick();
        if (xfer) begin
            repeat (OUT_LANES) void'(expq.pop_front());
            if (mbeat == 3) begin
                mbeat = 0;
                mrows--;
            end else begin
                mbeat++;
            end
        end
        if (push) begin
            for (int k = 0; k < SYS_COL; k++) expq.push_back(16'(next_id * 16 + k));
            next_id++;
            mrows++;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vt[0]  = '{32'h0000_0180,  5'd8, 16'h0002, 1'b0, "rnd_up"};
        vt[1]  = '{32'h0000_017F,  5'd8, 16'h0001, 1'b0, "rnd_dn"};
        vt[2]  = '{32'hFFFF_FE80,  5'd8, 16'hFFFF, 1'b0, "rnd_neg"};
        vt[3]  = '{32'd100,        5'd0, 16'h0064, 1'b0, "shift0"};
        vt[4]  = '{32'h0001_0000,  5'd0, 16'h7FFF, 1'b1, "sat_pos"};
        vt[5]  = '{32'hFFFF_0000,  5'd0, 16'h8000, 1'b1, "sat_neg"};
        vt[6]  = '{32'h0000_7FFF,  5'd0, 16'h7FFF, 1'b0, "max_nosat"};
        vt[7]  = '{32'hFFFF_8000,  5'd0, 16'h8000, 1'b0, "min_nosat"};
        vt[8]  = '{32'h0000_8000,  5'd0, 16'h7FFF, 1'b1, "max_plus1"};
        vt[9]  = '{32'hFFFF_7FFF,  5'd0, 16'h8000, 1'b1, "min_minus1"};
        vt[10] = '{32'h7FFF_FFFF,  5'd31, 16'h0001, 1'b0, "psum_max_sh31"};
        vt[11] = '{32'h8000_0000,  5'd31, 16'hFFFF, 1'b0, "psum_min_sh31"};
        vt[12] = '{32'hFFFF_FFFD,  5'd1, 16'hFFFF, 1'b0, "neg_half"};
        vt[13] = '{32'h1234_5678,  5'd16, 16'h1234, 1'b0, "mid_shift16"};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sat_clr   = 1'b0;
        set_row_const(32'd0, 5'd0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_sat_flag", 64'(bus.sat_flag), 64'd0);
        rst = 1'b0;

        // Single row, lane k = 256*k, shift 8 -> lane k; accepted at the first edge after reset.
        for (int k = 0; k < SYS_COL; k++) bus.in_data[k] = 32'(256 * k);
        bus.shift     = 5'd8;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            logic [63:0] e;
            e = '0;
            for (int i = 0; i < OUT_LANES; i++) e = (e << DATA_WIDTH) | 64'(b * OUT_LANES + i);
            chk("row_beat_valid", 64'(bus.out_valid), 64'd1);
            chk("row_beat_data", beat_word(), e);
            chk("row_beat_last", 64'(bus.out_last), 64'(b == 3));
            tick();
        end
        chk("row_drained", 64'(bus.out_valid), 64'd0);
        chk("row_no_sat", 64'(bus.sat_flag), 64'd0);
        bus.out_ready = 1'b0;

        foreach (vt[n]) begin
            bus.sat_clr = 1'b1;
            tick();
            bus.sat_clr = 1'b0;
            set_row_const(vt[n].val, vt[n].sh);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk({vt[n].name, "_data"}, beat_word(), {4{vt[n].exp}});
            chk({vt[n].name, "_sat"}, 64'(bus.sat_flag), 64'(vt[n].sat));
            bus.out_ready = 1'b1;
            repeat (4) tick();
            bus.out_ready = 1'b0;
            chk({vt[n].name, "_empty"}, 64'(bus.out_valid), 64'd0);
        end

        // Sticky flag: clear pulse, then clear coinciding with a saturating row.
        bus.sat_clr = 1'b1;
        tick();
        bus.sat_clr = 1'b0;
        set_row_const(32'h0001_0000, 5'd0);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("sat_set", 64'(bus.sat_flag), 64'd1);
        tick();
        chk("sat_sticky", 64'(bus.sat_flag), 64'd1);
        bus.sat_clr = 1'b1;
        tick();
        bus.sat_clr = 1'b0;
        chk("sat_cleared", 64'(bus.sat_flag), 64'd0);
        bus.sat_clr  = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.sat_clr  = 1'b0;
        bus.in_valid = 1'b0;
        chk("sat_set_wins", 64'(bus.sat_flag), 64'd1);
        bus.out_ready = 1'b1;
        repeat (8) tick();
        bus.out_ready = 1'b0;
        chk("sat_rows_drained", 64'(bus.out_valid), 64'd0);

        // Backpressure fill, final-beat pop at full, then random stress.
        mrows = 0; mbeat = 0; next_id = 0; id_limit = 5;
        expq.delete();
        repeat (5) mcycle(1'b1, 1'b0);
        chk("full_in_ready_low", 64'(bus.in_ready), 64'd0);
        repeat (4) mcycle(1'b1, 1'b1);
        chk("accept_after_pop", 64'(bus.in_ready), 64'd1);
        repeat (18) mcycle(1'b1, 1'b1);
        id_limit = 25;
        for (int c = 0; c < 300; c++) mcycle(($urandom % 3) != 0, ($urandom % 2) == 1);
        repeat (30) mcycle(1'b0, 1'b1);

        // Reset with three rows held and the head row on beat 2.
        mrows = 0; mbeat = 0; next_id = 0; id_limit = 3;
        expq.delete();
        repeat (3) mcycle(1'b1, 1'b0);
        repeat (2) mcycle(1'b0, 1'b1);
        bus.out_ready = 1'b0;
        chk("pre_rst_beat2", 64'(bus.out_data[0]), 64'd8);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_last", 64'(bus.out_last), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mrows = 0; mbeat = 0; next_id = 7; id_limit = 8;
        expq.delete();
        mcycle(1'b1, 1'b0);
        repeat (5) mcycle(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/out_requant_stream.md
OUT_REQUANT_STREAM -- requirements
Module: out_requant_stream

Interface
REQ-001 Parameters: SYS_COL, 16, output lanes per captured row; DATA_WIDTH, 16, output element width; OUT_LANES, 4, elements per output beat (divides SYS_COL); ROW_DEPTH, 4, buffered rows (power of 2); PSUM_WIDTH = 2*DATA_WIDTH (localparam); BEATS = SYS_COL/OUT_LANES (localparam).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  row of accumulator/ReLU results present on in_data.
REQ-005 in_ready  output  1  block can accept a row this cycle.
REQ-006 in_data  input  PSUM_WIDTH x SYS_COL (unpacked [0:SYS_COL-1])  one output-memory row, signed two's complement.
REQ-007 shift  input  5  requantization right-shift, sampled with each accepted row.
REQ-008 out_valid  output  1  out_data holds a valid beat.
REQ-009 out_ready  input  1  downstream accepts beat.
REQ-010 out_data  output  DATA_WIDTH x OUT_LANES (unpacked [0:OUT_LANES-1])  requantized elements.
REQ-011 out_last  output  1  current beat is last beat of its row.
REQ-012 sat_flag  output  1  sticky: some element saturated since last clear.
REQ-013 sat_clr  input  1  synchronous clear of sat_flag.

Function
REQ-014 Row accepted iff in_valid && in_ready at a rising edge; requantized at acceptance, written to ROW_DEPTH-entry row FIFO.
REQ-015 Requant per lane: shift==0 -> value unchanged before saturation; shift>0 -> v + (1 << (shift-1)) in PSUM_WIDTH+1 bits, then arithmetic shift right by shift.
REQ-016 Saturation: result > 2^(DATA_WIDTH-1)-1 -> 0x7FFF; < -2^(DATA_WIDTH-1) -> 0x8000 (DATA_WIDTH=16); any saturated lane in an accepted row sets sat_flag next cycle.
REQ-017 shift values > PSUM_WIDTH-1 treated as PSUM_WIDTH-1.
REQ-018 in_ready = (row count < ROW_DEPTH); registered-state only, no combinational path from out_ready or in_valid.
REQ-019 out_valid = (row count != 0); no combinational path from in_valid.
REQ-020 out_data[i] = head row lane beat_idx*OUT_LANES + i; beat_idx is a 0..BEATS-1 counter.
REQ-021 Beat transfer on out_valid && out_ready: beat_idx increments; at beat_idx==BEATS-1 it wraps to 0 and head row pops.
REQ-022 out_last = out_valid && (beat_idx == BEATS-1).
REQ-023 out_data/out_last held stable while out_valid && !out_ready.
REQ-024 Latency: row accepted at edge N -> first beat on out_valid after edge N when FIFO was empty (1 cycle); full throughput 1 beat/cycle.
REQ-025 Simultaneous push and final-beat pop: count unchanged, both succeed; when full, push blocked (in_ready=0) even if pop occurs that cycle.
REQ-026 Read/write pointers log2(ROW_DEPTH) bits, wrap modulo ROW_DEPTH; count log2(ROW_DEPTH)+1 bits.
REQ-027 sat_clr and new saturation same cycle: sat_flag = 1 (set wins).
REQ-028 in_valid while in_ready=0: row ignored, no state change (producer must hold).

Reset
REQ-029 rst asserted: pointers, count, beat_idx, sat_flag -> 0 immediately; out_valid=0, out_last=0, in_ready=1 while asserted and after.
REQ-030 rst mid-operation: buffered rows discarded; out_data contents don't-care while out_valid=0.
REQ-031 First accept possible at first edge after rst deasserts.

Verification
REQ-032 Single row, lanes k=0..15 value 256*k, shift=8, out_ready=1 -> 4 beats {0,1,2,3},{4,5,6,7},{8..11},{12..15}; out_last on beat 4 only; sat_flag=0.
REQ-033 Rounding: lane 0x00000180 shift=8 -> 2; 0x0000017F -> 1; -384 (0xFFFFFE80) shift=8 -> -1; shift=0 lane 100 -> 100.
REQ-034 Saturation: lane 0x00010000 shift=0 -> 0x7FFF, 0xFFFF0000 -> 0x8000, sat_flag=1 next cycle; sat_clr pulse -> 0; sat_clr same cycle as saturating row -> stays 1.
REQ-035 Backpressure: out_ready=0, push 5 rows back-to-back -> 4 accepted, in_ready=0 after 4th; release out_ready -> 16 beats in order, rows 0..3 intact, 5th row accepted once count<4.
REQ-036 Concurrent push/pop at full on final beat: count stays 4, in_ready stays 0 that cycle, next row accepted following cycle; random out_ready stress with scoreboard shows no loss/reorder.
REQ-037 Reset with 3 rows buffered and beat_idx=2 -> out_valid=0 immediately, in_ready=1; new row after reset emits from beat 0.
